// File: rtl/ysyx_23060221_axi_pkg.sv
// rtl/ysyx_23060221_axi_pkg.sv - shared types and constants for the AXI arbiter
// Purpose: arbiter state encoding, master index constants, grant vector bit
//          positions and AXI response codes.
// Ports:   none (package).
package ysyx_23060221_axi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_M0 = 2'd1,
    RD_M1 = 2'd2,
    WR_M1 = 2'd3
  } arb_state_e;

  // Master index, also the low bit of the id sent downstream.
  localparam logic M0_IDX = 1'b0;
  localparam logic M1_IDX = 1'b1;

  // Bit positions inside the one-hot grant vector.
  localparam int G_RD_M0 = 0;
  localparam int G_RD_M1 = 1;
  localparam int G_WR_M1 = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_23060221_arb_pick.sv
// rtl/ysyx_23060221_arb_pick.sv - combinational grant selector
// Purpose: turns the three request lines into a one-hot grant. m1 write always
//          beats m1 read; between m0 and m1 the tie goes to m1 unless m1 was
//          the last master granted.
// Ports:   m0_rd_req, m1_rd_req, m1_wr_req - pending requests
//          last_grant                     - index of the last granted master
//          grant[2:0]                     - one-hot {wr_m1, rd_m1, rd_m0}
module ysyx_23060221_arb_pick
  import ysyx_23060221_axi_pkg::*;
(
  input  logic       m0_rd_req,
  input  logic       m1_rd_req,
  input  logic       m1_wr_req,
  input  logic       last_grant,
  output logic [2:0] grant
);

  logic m1_req;
  logic m1_wins;

  assign m1_req  = m1_rd_req | m1_wr_req;
  // m0 only takes a contested cycle when m1 was served last.
  assign m1_wins = m1_req & ~(m0_rd_req & (last_grant == M1_IDX));

  always_comb begin
    grant = 3'b000;
    if (m1_wins) begin
      if (m1_wr_req) grant[G_WR_M1] = 1'b1;
      else           grant[G_RD_M1] = 1'b1;
    end else if (m0_rd_req) begin
      grant[G_RD_M0] = 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_23060221_axi_arbiter.sv
// rtl/ysyx_23060221_axi_arbiter.sv - 2-master to 1-slave AXI arbiter
// Purpose: shares one AXI slave port between the IFU (m0, read only) and the
//          LSU (m1, read and write). Requests are sampled in IDLE, the grant
//          takes effect one cycle later and channels are then passed through
//          combinationally until the last R beat or the B response.
// Ports:   clk, reset            - clock, asynchronous active-high reset
//          m0_ar*/m0_r*           - IFU read channels
//          m1_ar*/m1_r*           - LSU read channels
//          m1_aw*/m1_w*/m1_b*     - LSU write channels
//          s_*                    - downstream slave port
// Config:  YSYX_23060221_ARB_RR_EN - round-robin m0/m1 arbitration (default:
//          fixed priority m1 write > m1 read > m0 read).
module ysyx_23060221_axi_arbiter
  import ysyx_23060221_axi_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_arvalid,
  output logic          m0_arready,
  input  logic [AW-1:0] m0_araddr,
  input  logic [3:0]    m0_arid,
  input  logic [7:0]    m0_arlen,
  input  logic [2:0]    m0_arsize,
  input  logic [1:0]    m0_arburst,
  output logic          m0_rvalid,
  input  logic          m0_rready,
  output logic [DW-1:0] m0_rdata,
  output logic [1:0]    m0_rresp,
  output logic          m0_rlast,
  output logic [3:0]    m0_rid,
  input  logic          m1_arvalid,
  output logic          m1_arready,
  input  logic [AW-1:0] m1_araddr,
  input  logic [3:0]    m1_arid,
  input  logic [7:0]    m1_arlen,
  input  logic [2:0]    m1_arsize,
  input  logic [1:0]    m1_arburst,
  output logic          m1_rvalid,
  input  logic          m1_rready,
  output logic [DW-1:0] m1_rdata,
  output logic [1:0]    m1_rresp,
  output logic          m1_rlast,
  output logic [3:0]    m1_rid,
  input  logic          m1_awvalid,
  output logic          m1_awready,
  input  logic [AW-1:0] m1_awaddr,
  input  logic [3:0]    m1_awid,
  input  logic [7:0]    m1_awlen,
  input  logic [2:0]    m1_awsize,
  input  logic [1:0]    m1_awburst,
  input  logic          m1_wvalid,
  output logic          m1_wready,
  input  logic [DW-1:0] m1_wdata,
  input  logic [7:0]    m1_wstrb,
  input  logic          m1_wlast,
  output logic          m1_bvalid,
  input  logic          m1_bready,
  output logic [1:0]    m1_bresp,
  output logic [3:0]    m1_bid,
  output logic          s_arvalid,
  input  logic          s_arready,
  output logic [AW-1:0] s_araddr,
  output logic [3:0]    s_arid,
  output logic [7:0]    s_arlen,
  output logic [2:0]    s_arsize,
  output logic [1:0]    s_arburst,
  input  logic          s_rvalid,
  output logic          s_rready,
  input  logic [DW-1:0] s_rdata,
  input  logic [1:0]    s_rresp,
  input  logic          s_rlast,
  input  logic [3:0]    s_rid,
  output logic          s_awvalid,
  input  logic          s_awready,
  output logic [AW-1:0] s_awaddr,
  output logic [3:0]    s_awid,
  output logic [7:0]    s_awlen,
  output logic [2:0]    s_awsize,
  output logic [1:0]    s_awburst,
  output logic          s_wvalid,
  input  logic          s_wready,
  output logic [DW-1:0] s_wdata,
  output logic [7:0]    s_wstrb,
  output logic          s_wlast,
  input  logic          s_bvalid,
  output logic          s_bready,
  input  logic [1:0]    s_bresp,
  input  logic [3:0]    s_bid
);

  arb_state_e state_q, state_d;
  logic [3:0] id_q, id_d;
  logic       addr_done_q, addr_done_d;
  logic [2:0] grant;
  logic       pick_last;

  // The slave only ever sees {3'b0, idx}; the master's own id is replayed
  // from id_q, so the returned slave ids carry no extra information.
  logic unused_ids;
  assign unused_ids = ^{s_rid, s_bid};

  ysyx_23060221_arb_pick u_pick (
    .m0_rd_req  (m0_arvalid),
    .m1_rd_req  (m1_arvalid),
    .m1_wr_req  (m1_awvalid),
    .last_grant (pick_last),
    .grant      (grant)
  );

`ifdef YSYX_23060221_ARB_RR_EN
  logic last_grant_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= M0_IDX;
    else if (state_q == IDLE && grant != 3'b000)
      last_grant_q <= grant[G_RD_M0] ? M0_IDX : M1_IDX;
  end
  assign pick_last = last_grant_q;
`else
  // Pretending m0 always went last makes the picker a fixed m1-first priority.
  assign pick_last = M0_IDX;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      id_q        <= 4'd0;
      addr_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_done_q <= addr_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = RESP_OKAY;
    m0_rlast   = 1'b0;
    m0_rid     = 4'd0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = RESP_OKAY;
    m1_rlast   = 1'b0;
    m1_rid     = 4'd0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m1_bresp   = RESP_OKAY;
    m1_bid     = 4'd0;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_arid     = 4'd0;
    s_arlen    = 8'd0;
    s_arsize   = 3'd0;
    s_arburst  = 2'd0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_awid     = 4'd0;
    s_awlen    = 8'd0;
    s_awsize   = 3'd0;
    s_awburst  = 2'd0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = 8'd0;
    s_wlast    = 1'b0;
    s_bready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant[G_WR_M1]) begin
          state_d = WR_M1;
          id_d    = m1_awid;
        end else if (grant[G_RD_M1]) begin
          state_d = RD_M1;
          id_d    = m1_arid;
        end else if (grant[G_RD_M0]) begin
          state_d = RD_M0;
          id_d    = m0_arid;
        end
      end
      // addr_done_q blocks a second address from leaking through while the
      // granted burst is still outstanding.
      RD_M0: begin
        s_arvalid  = m0_arvalid & ~addr_done_q;
        m0_arready = s_arready & ~addr_done_q;
        s_araddr   = m0_araddr;
        s_arid     = {3'b000, M0_IDX};
        s_arlen    = m0_arlen;
        s_arsize   = m0_arsize;
        s_arburst  = m0_arburst;
        s_rready   = m0_rready;
        m0_rvalid  = s_rvalid;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rlast   = s_rlast;
        m0_rid     = id_q;
        if (s_rvalid & m0_rready & s_rlast) state_d = IDLE;
      end
      RD_M1: begin
        s_arvalid  = m1_arvalid & ~addr_done_q;
        m1_arready = s_arready & ~addr_done_q;
        s_araddr   = m1_araddr;
        s_arid     = {3'b000, M1_IDX};
        s_arlen    = m1_arlen;
        s_arsize   = m1_arsize;
        s_arburst  = m1_arburst;
        s_rready   = m1_rready;
        m1_rvalid  = s_rvalid;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rlast   = s_rlast;
        m1_rid     = id_q;
        if (s_rvalid & m1_rready & s_rlast) state_d = IDLE;
      end
      WR_M1: begin
        s_awvalid  = m1_awvalid & ~addr_done_q;
        m1_awready = s_awready & ~addr_done_q;
        s_awaddr   = m1_awaddr;
        s_awid     = {3'b000, M1_IDX};
        s_awlen    = m1_awlen;
        s_awsize   = m1_awsize;
        s_awburst  = m1_awburst;
        s_wvalid   = m1_wvalid;
        m1_wready  = s_wready;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wlast    = m1_wlast;
        s_bready   = m1_bready;
        m1_bvalid  = s_bvalid;
        m1_bresp   = s_bresp;
        m1_bid     = id_q;
        if (s_bvalid & m1_bready) state_d = IDLE;
      end
    endcase
    addr_done_d = addr_done_q | (s_arvalid & s_arready) | (s_awvalid & s_awready);
    if (state_d == IDLE) addr_done_d = 1'b0;
  end

endmodule

// File: tb/tb_ysyx_23060221_axi_arbiter.sv
// tb/tb_ysyx_23060221_axi_arbiter.sv - self-checking bench for the AXI arbiter
module tb_ysyx_23060221_axi_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam logic [DW-1:0] RDATA_C = 64'hDEAD_BEEF_0000_0001;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [AW-1:0] m0_araddr;
  logic [3:0]    m0_arid, m0_rid;
  logic [7:0]    m0_arlen;
  logic [2:0]    m0_arsize;
  logic [1:0]    m0_arburst, m0_rresp;
  logic [DW-1:0] m0_rdata;
  logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [AW-1:0] m1_araddr;
  logic [3:0]    m1_arid, m1_rid;
  logic [7:0]    m1_arlen;
  logic [2:0]    m1_arsize;
  logic [1:0]    m1_arburst, m1_rresp;
  logic [DW-1:0] m1_rdata;
  logic          m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;
  logic [AW-1:0] m1_awaddr;
  logic [3:0]    m1_awid, m1_bid;
  logic [7:0]    m1_awlen, m1_wstrb;
  logic [2:0]    m1_awsize;
  logic [1:0]    m1_awburst, m1_bresp;
  logic [DW-1:0] m1_wdata;
  logic          s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [AW-1:0] s_araddr, s_awaddr;
  logic [3:0]    s_arid, s_rid, s_awid, s_bid;
  logic [7:0]    s_arlen, s_awlen, s_wstrb;
  logic [2:0]    s_arsize, s_awsize;
  logic [1:0]    s_arburst, s_rresp, s_awburst, s_bresp;
  logic [DW-1:0] s_rdata, s_wdata;
  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;

  ysyx_23060221_axi_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rid(m0_rid),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rid(m1_rid),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
    .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .m1_bid(m1_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid)
  );

  always #5 clk = ~clk;

  // vin : {m0_arv, m1_arv, m1_awv, m1_wv}_{s_arrdy, s_awrdy, s_wrdy}_{s_rv, s_rlast, s_bv}_{m0_rrdy, m1_rrdy, m1_brdy}
  // vexp: {s_arv, s_awv, s_wv}_{m0_arrdy, m1_arrdy, m1_awrdy}_{m0_rv, m1_rv, m1_bv}_{s_rrdy, s_brdy}
  // own : 0 none, 1 m0 read, 2 m1 read, 3 m1 write
  typedef struct {
    string       name;
    logic [12:0] vin;
    logic [10:0] vexp;
    logic [1:0]  own;
  } vec_t;

  vec_t vt[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [10:0] flags();
    return {s_arvalid, s_awvalid, s_wvalid, m0_arready, m1_arready, m1_awready,
            m0_rvalid, m1_rvalid, m1_bvalid, s_rready, s_bready};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [12:0] i, input logic [10:0] e, input logic [1:0] o);
    vec_t v;
    v.name = n; v.vin = i; v.vexp = e; v.own = o;
    vt.push_back(v);
  endtask

  task automatic drive(input logic [12:0] v);
    {m0_arvalid, m1_arvalid, m1_awvalid, m1_wvalid, s_arready, s_awready, s_wready,
     s_rvalid, s_rlast, s_bvalid, m0_rready, m1_rready, m1_bready} = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_owner(input string n, input logic [1:0] own);
    case (own)
      2'd1: begin
        check({n, "_araddr"}, s_araddr, 32'h8000_0000);
        check({n, "_arid"},   s_arid, 4'd0);
        check({n, "_arlen"},  s_arlen, 8'd0);
        check({n, "_rid"},    m0_rid, 4'h5);
        check({n, "_rdata"},  m0_rdata, RDATA_C);
      end
      2'd2: begin
        check({n, "_araddr"}, s_araddr, 32'h8000_0200);
        check({n, "_arid"},   s_arid, 4'd1);
        check({n, "_arlen"},  s_arlen, 8'd3);
        check({n, "_rid"},    m1_rid, 4'h9);
        check({n, "_rdata"},  m1_rdata, RDATA_C);
      end
      2'd3: begin
        check({n, "_awaddr"}, s_awaddr, 32'h8000_0100);
        check({n, "_awid"},   s_awid, 4'd1);
        check({n, "_wdata"},  s_wdata, 64'h1234_5678);
        check({n, "_wstrb"},  s_wstrb, 8'h0F);
        check({n, "_bid"},    m1_bid, 4'hA);
        check({n, "_bresp"},  m1_bresp, 2'b10);
      end
      default: ;
    endcase
  endtask

  initial begin
    int       beat, rx_n, ng;
    logic     hs;
    logic     got [4];
    logic     exp_g [4];

    reset = 1'b1;
    drive(13'd0);
    m0_araddr = 32'h8000_0000; m0_arid = 4'h5; m0_arlen = 8'd0; m0_arsize = 3'd2; m0_arburst = 2'b01;
    m1_araddr = 32'h8000_0200; m1_arid = 4'h9; m1_arlen = 8'd3; m1_arsize = 3'd3; m1_arburst = 2'b01;
    m1_awaddr = 32'h8000_0100; m1_awid = 4'hA; m1_awlen = 8'd0; m1_awsize = 3'd2; m1_awburst = 2'b01;
    m1_wdata = 64'h1234_5678; m1_wstrb = 8'h0F; m1_wlast = 1'b1;
    s_rdata = RDATA_C; s_rresp = 2'b00; s_rid = 4'd0; s_bresp = 2'b10; s_bid = 4'd1;

    // m0 alone
    add("m0_req_idle",  13'b1000_000_000_100, 11'b000_000_000_00, 2'd0);
    add("m0_ar_hs",     13'b1000_100_000_100, 11'b100_100_000_10, 2'd1);
    add("m0_r_last",    13'b0000_000_110_100, 11'b000_000_100_10, 2'd1);
    add("m0_idle",      13'b0000_000_110_100, 11'b000_000_000_00, 2'd0);
    // m0 read and m1 write together: write first
    add("both_idle",    13'b1011_000_000_101, 11'b000_000_000_00, 2'd0);
    add("wr_aw_w",      13'b1011_111_000_101, 11'b011_001_000_01, 2'd3);
    add("wr_wait_b",    13'b1000_100_000_101, 11'b000_000_000_01, 2'd3);
    add("wr_b_hs",      13'b1000_100_001_101, 11'b000_000_001_01, 2'd3);
    add("wr_idle",      13'b1000_100_000_101, 11'b000_000_000_00, 2'd0);
    add("m0_after_wr",  13'b1000_100_000_101, 11'b100_100_000_10, 2'd1);
    add("m0_r_done",    13'b0000_000_110_101, 11'b000_000_100_10, 2'd1);
    add("idle2",        13'b0000_000_000_000, 11'b000_000_000_00, 2'd0);
    // m1 read, 4 beats
    add("m1_req_idle",  13'b0100_000_000_110, 11'b000_000_000_00, 2'd0);
    add("m1_ar_hs",     13'b0100_100_000_110, 11'b100_010_000_10, 2'd2);
    add("m1_beat1",     13'b0000_000_100_110, 11'b000_000_010_10, 2'd2);
    add("m1_beat2",     13'b0000_000_100_110, 11'b000_000_010_10, 2'd2);
    add("m1_beat3",     13'b0000_000_100_110, 11'b000_000_010_10, 2'd2);
    add("m1_beat4",     13'b0000_000_110_110, 11'b000_000_010_10, 2'd2);
    add("m1_idle",      13'b0000_000_110_110, 11'b000_000_000_00, 2'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_flags", flags(), 11'd0);
    check("reset_wready", m1_wready, 1'b0);
    step();
    reset = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].vin);
      @(negedge clk);
      check(vt[i].name, flags(), vt[i].vexp);
      check_owner(vt[i].name, vt[i].own);
      step();
    end

    // back-pressure: m1 holds rready low for 5 cycles after the first beat
    drive(13'd0);
    m1_arvalid = 1'b1; m1_rready = 1'b1;
    step();
    s_arready = 1'b1;
    @(negedge clk);
    check("bp_arready", m1_arready, 1'b1);
    step();
    m1_arvalid = 1'b0; s_arready = 1'b0;
    beat = 0; rx_n = 0;
    for (int cyc = 0; cyc < 30 && beat < 4; cyc++) begin
      s_rvalid  = 1'b1;
      s_rdata   = 64'(100 + beat);
      s_rlast   = (beat == 3);
      m1_rready = !(cyc >= 1 && cyc <= 5);
      @(negedge clk);
      if (cyc >= 1 && cyc <= 5) check("bp_hold_rvalid", m1_rvalid, 1'b1);
      if (m1_rvalid && m1_rready) begin
        check("bp_beat_data", m1_rdata, 64'(100 + rx_n));
        rx_n++;
      end
      hs = s_rvalid & s_rready;
      step();
      if (hs) beat++;
    end
    check("bp_beat_count", rx_n, 4);
    s_rlast = 1'b0;
    @(negedge clk);
    check("bp_back_idle", m1_rvalid, 1'b0);
    s_rdata = RDATA_C;
    step();

    // reset during beat 2 of a 4-beat m1 read
    drive(13'd0);
    m1_arvalid = 1'b1; m1_rready = 1'b1;
    step();
    s_arready = 1'b1;
    step();
    m1_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1;
    step();
    @(negedge clk);
    check("rst_pre_rvalid", m1_rvalid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_flags", flags(), 11'd0);
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_idle_flags", flags(), 11'd0);
    step();
    drive(13'd0);
    m0_arvalid = 1'b1; m0_rready = 1'b1;
    step();
    s_arready = 1'b1;
    @(negedge clk);
    check("rst_next_arready", m0_arready, 1'b1);
    check("rst_next_araddr", s_araddr, 32'h8000_0000);
    step();
    m0_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1;
    @(negedge clk);
    check("rst_next_rvalid", m0_rvalid, 1'b1);
    check("rst_next_rid", m0_rid, 4'h5);
    step();
    @(negedge clk);
    check("rst_next_idle", m0_rvalid, 1'b0);

    // both masters hold AR continuously; record who wins each grant
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(13'd0);
    m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_arready = 1'b1;
    s_rvalid = 1'b1; s_rlast = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
`ifdef YSYX_23060221_ARB_RR_EN
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    ng = 0;
    for (int c = 0; c < 20 && ng < 4; c++) begin
      @(negedge clk);
      if (m0_arready || m1_arready) begin
        got[ng] = m1_arready;
        ng++;
      end
      step();
    end
    check("arb_grant_count", ng, 4);
    for (int i = 0; i < 4 && i < ng; i++) check($sformatf("arb_grant_%0d_is_m1", i), got[i], exp_g[i]);
    drive(13'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
